// File: rtl/seq_note_divider_pkg.sv
// Shared types and constants for the note-index divider and its neighbouring lookup blocks.
package seq_note_divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Default chromatic octave size, shared with the octave/pitch lookup blocks.
  localparam int unsigned NotesPerOctave = 12;

endpackage

// File: rtl/seq_note_divider_div_step.sv
// Combinational single restoring-division step: shift in one dividend bit, trial subtract.
module seq_note_divider_div_step #(
  parameter int unsigned DIV_W = 4
) (
  input  logic [DIV_W:0]   p_i,
  input  logic             bit_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic [DIV_W:0]   p_o,
  output logic             q_bit_o
);

  logic [DIV_W:0] shifted;
  logic [DIV_W:0] div_ext;

  // p_i is always below the divisor, so dropping its top bit loses nothing.
  assign shifted = {p_i[DIV_W-1:0], bit_i};
  assign div_ext = {1'b0, divisor_i};
  assign q_bit_o = (shifted >= div_ext);
  assign p_o     = q_bit_o ? (shifted - div_ext) : shifted;

endmodule

// File: rtl/seq_note_divider.sv
// Multi-cycle restoring divider: note index -> octave (quotient) and note in octave (remainder).
module seq_note_divider
  import seq_note_divider_pkg::*;
#(
  parameter int unsigned NUM_W = 8,
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [NUM_W-1:0] numerator_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [NUM_W-1:0] quotient_o,
  output logic [DIV_W-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int unsigned CntW = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  state_e           state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W:0]   p_q, p_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [NUM_W-1:0] quotient_q, quotient_d;
  logic [DIV_W-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [DIV_W:0]   p_next;
  logic             q_bit;
  logic [NUM_W-1:0] quo_next;

  seq_note_divider_div_step #(
    .DIV_W (DIV_W)
  ) u_div_step (
    .p_i       (p_q),
    .bit_i     (num_q[NUM_W-1]),
    .divisor_i (div_q),
    .p_o       (p_next),
    .q_bit_o   (q_bit)
  );

  assign quo_next = {quo_q[NUM_W-2:0], q_bit};

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    div_d       = div_q;
    p_d         = p_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          num_d = numerator_i;
          div_d = divisor_i;
          p_d   = '0;
          quo_d = '0;
          cnt_d = CntW'(NUM_W - 1);
          if (divisor_i == '0) begin
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = '0;
            div_zero_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        p_d   = p_next;
        num_d = num_q << 1;
        quo_d = quo_next;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d     = StDone;
          quotient_d  = quo_next;
          remainder_d = p_next[DIV_W-1:0];
          div_zero_d  = 1'b0;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      num_q       <= '0;
      div_q       <= '0;
      p_q         <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      div_q       <= div_d;
      p_q         <= p_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_seq_note_divider.sv
// Directed bench for seq_note_divider: latency, boundary cases, backpressure, reset abort.
module tb_seq_note_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] numerator;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  int vecs = 0;
  int errs = 0;

  seq_note_divider #(
    .NUM_W (8),
    .DIV_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .numerator_i (numerator),
    .divisor_i   (divisor),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .div_zero_o  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand pair for a single accept edge, then scramble the inputs.
  task automatic send(input logic [7:0] n, input logic [3:0] d);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    numerator = n;
    divisor   = d;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    numerator = ~n;
    divisor   = ~d;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("take_out_valid", 32'(out_valid), 32'd0);
    check("take_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run(input logic [7:0] n, input logic [3:0] d, input logic [7:0] eq,
                     input logic [3:0] er, input logic ez, input int elat);
    int edges;
    send(n, d);
    wait_done(edges);
    check("latency", 32'(edges), 32'(elat));
    check("out_valid", 32'(out_valid), 32'd1);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_zero", 32'(div_zero), 32'(ez));
    take();
  endtask

  initial begin
    int         edges;
    logic [7:0] rn;
    logic [3:0] rd;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    numerator = '0;
    divisor   = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(8'd61, 4'd12, 8'd5, 4'd1, 1'b0, 8);
    run(8'd255, 4'd12, 8'd21, 4'd3, 1'b0, 8);
    run(8'd255, 4'd7, 8'd36, 4'd3, 1'b0, 8);
    run(8'd37, 4'd0, 8'hFF, 4'd0, 1'b1, 0);
    run(8'd0, 4'd9, 8'd0, 4'd0, 1'b0, 8);
    run(8'd200, 4'd1, 8'd200, 4'd0, 1'b0, 8);
    run(8'd13, 4'd15, 8'd0, 4'd13, 1'b0, 8);

    // Backpressure: result held for 20 cycles with out_ready low.
    send(8'd100, 4'd5);
    wait_done(edges);
    check("bp_latency", 32'(edges), 32'd8);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quotient", 32'(quotient), 32'd20);
      check("bp_remainder", 32'(remainder), 32'd0);
    end
    take();
    check("bp_hold_quotient", 32'(quotient), 32'd20);

    // Reset three cycles into a division.
    send(8'd50, 4'd7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("abandoned_out_valid", 32'(out_valid), 32'd0);
    end
    run(8'd24, 4'd12, 8'd2, 4'd0, 1'b0, 8);

    for (int i = 0; i < 60; i++) begin
      rn = 8'($urandom_range(0, 255));
      rd = 4'($urandom_range(1, 15));
      run(rn, rd, rn / 8'(rd), 4'(rn % 8'(rd)), 1'b0, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
